// File: rtl/uart_frame_rx_if.sv
// Byte-in / memory-write / frame-status bundle between uart_rx, uart_frame_rx and the rx buffer.
// The slave side is the framer; the master side feeds bytes and consumes writes and status.
interface uart_frame_rx_if #(
    parameter int ADDR_W = 10
);
    logic              i_rx_dv;
    logic [7:0]        i_rx_byte;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;
    logic              o_frame_done;
    logic [7:0]        o_frame_len;
    logic              o_frame_bank;
    logic              o_frame_err;
    logic [1:0]        o_err_code;
    logic              o_busy;

    modport master (
        output i_rx_dv, i_rx_byte,
        input  o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_frame_done, o_frame_len, o_frame_bank,
        input  o_frame_err, o_err_code, o_busy
    );

    modport slave (
        input  i_rx_dv, i_rx_byte,
        output o_mem_we, o_mem_addr, o_mem_wdata,
        output o_frame_done, o_frame_len, o_frame_bank,
        output o_frame_err, o_err_code, o_busy
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART frame parser: SOF, LEN, payload, XOR checksum -> double-buffered rx memory; 1-cycle latency, no backpressure.
// Optional inter-byte timeout enabled by defining FRAME_RX_TIMEOUT_EN.
module uart_frame_rx #(
    parameter logic [7:0] SOF_BYTE    = 8'h02,
    parameter int         ADDR_W      = 10,
    parameter int         MAX_LEN     = 64,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          reset,
    uart_frame_rx_if.slave bus
);
    localparam int         IDX_W     = ADDR_W - 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || MAX_LEN > (1 << IDX_W) || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("uart_frame_rx: illegal MAX_LEN/ADDR_W/TIMEOUT_CYC combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t            r_state, w_state;
    logic [7:0]        r_len, w_len;
    logic [IDX_W-1:0]  r_idx, w_idx;
    logic [7:0]        r_chk, w_chk;
    logic              r_bank, w_bank;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [7:0]        r_mem_wdata, w_mem_wdata;
    logic              r_done, w_done;
    logic [7:0]        r_frame_len, w_frame_len;
    logic              r_frame_bank, w_frame_bank;
    logic              r_err, w_err;
    logic [1:0]        r_err_code, w_err_code;
    logic              r_busy;
    logic              w_last;

    assign w_last = (r_idx + IDX_W'(1)) == IDX_W'(r_len);

`ifdef FRAME_RX_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC);

    logic [TCNT_W-1:0] r_tcnt, w_tcnt;
    logic              w_expire;

    // Expiry is detected one cycle early so the registered error lands TIMEOUT_CYC cycles after the last byte.
    assign w_expire = (r_state != S_IDLE) && !bus.i_rx_dv && (r_tcnt == TCNT_W'(TIMEOUT_CYC - 2));

    always_comb begin
        w_tcnt = '0;
        if (!bus.i_rx_dv && r_state != S_IDLE && !w_expire)
            w_tcnt = r_tcnt + TCNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tcnt <= '0;
        else
            r_tcnt <= w_tcnt;
    end
`endif

    always_comb begin
        w_state      = r_state;
        w_len        = r_len;
        w_idx        = r_idx;
        w_chk        = r_chk;
        w_bank       = r_bank;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_done       = 1'b0;
        w_frame_len  = r_frame_len;
        w_frame_bank = r_frame_bank;
        w_err        = 1'b0;
        w_err_code   = r_err_code;

        if (bus.i_rx_dv) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_rx_byte == SOF_BYTE)
                        w_state = S_LEN;
                end
                S_LEN: begin
                    if (bus.i_rx_byte == 8'd0 || bus.i_rx_byte > MAX_LEN_B) begin
                        w_err      = 1'b1;
                        w_err_code = 2'd1;
                        w_state    = S_IDLE;
                    end else begin
                        w_len   = bus.i_rx_byte;
                        w_chk   = bus.i_rx_byte;
                        w_idx   = '0;
                        w_state = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = {r_bank, r_idx};
                    w_mem_wdata = bus.i_rx_byte;
                    w_chk       = r_chk ^ bus.i_rx_byte;
                    w_idx       = r_idx + IDX_W'(1);
                    if (w_last)
                        w_state = S_CHK;
                end
                S_CHK: begin
                    // Bank flips only on success so the reader keeps ownership of o_frame_bank.
                    if (bus.i_rx_byte == r_chk) begin
                        w_done       = 1'b1;
                        w_frame_len  = r_len;
                        w_frame_bank = r_bank;
                        w_bank       = ~r_bank;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = 2'd2;
                    end
                    w_state = S_IDLE;
                end
                default: w_state = S_IDLE;
            endcase
        end

`ifdef FRAME_RX_TIMEOUT_EN
        if (w_expire) begin
            w_err      = 1'b1;
            w_err_code = 2'd3;
            w_state    = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_idx        <= '0;
            r_chk        <= '0;
            r_bank       <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_done       <= 1'b0;
            r_frame_len  <= '0;
            r_frame_bank <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_len        <= w_len;
            r_idx        <= w_idx;
            r_chk        <= w_chk;
            r_bank       <= w_bank;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_done       <= w_done;
            r_frame_len  <= w_frame_len;
            r_frame_bank <= w_frame_bank;
            r_err        <= w_err;
            r_err_code   <= w_err_code;
            r_busy       <= (w_state != S_IDLE);
        end
    end

    assign bus.o_mem_we     = r_mem_we;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_mem_wdata  = r_mem_wdata;
    assign bus.o_frame_done = r_done;
    assign bus.o_frame_len  = r_frame_len;
    assign bus.o_frame_bank = r_frame_bank;
    assign bus.o_frame_err  = r_err;
    assign bus.o_err_code   = r_err_code;
    assign bus.o_busy       = r_busy;
endmodule
